// File: rtl/alu_arbiter_pkg.sv
// Shared ALU types plus the arbiter state encoding and requester count.
package alu_arbiter_pkg;

   typedef logic [3:0] alu_control_t;

   localparam alu_control_t ALU_ADD = 4'd1;
   localparam alu_control_t ALU_SUB = 4'd2;
   localparam alu_control_t ALU_AND = 4'd3;
   localparam alu_control_t ALU_OR  = 4'd5;
   localparam alu_control_t ALU_SLL = 4'd6;
   localparam alu_control_t ALU_SRA = 4'd7;

   localparam int ALU_ARB_NUM_REQ = 2;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_EXEC,
      ARB_RESP
   } alu_arb_state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: add/sub/and/or/sll/sra with overflow, zero, equal flags.
module alu
   import alu_arbiter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  alu_control_t control,
   output logic [N-1:0] result,
   output logic         overflow,
   output logic         zero,
   output logic         equal
);

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (control)
         ALU_ADD: begin
            result   = a + b;
            overflow = (a[N-1] == b[N-1]) && (result[N-1] != a[N-1]);
         end
         ALU_SUB: begin
            result   = a - b;
            overflow = (a[N-1] != b[N-1]) && (result[N-1] != a[N-1]);
         end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         // Full-width shift amount: shifting by N or more clears the word
         ALU_SLL: result = a << b;
         ALU_SRA: result = N'($signed(a) >>> b);
         default: result = '0;
      endcase
   end

   assign zero  = (result == '0);
   assign equal = (a == b);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for one registered ALU op at a time.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; default is fixed priority.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [ALU_ARB_NUM_REQ-1:0]             req_valid,
   output logic [ALU_ARB_NUM_REQ-1:0]             req_ready,
   input  logic [ALU_ARB_NUM_REQ-1:0][N-1:0]      req_a,
   input  logic [ALU_ARB_NUM_REQ-1:0][N-1:0]      req_b,
   input  alu_control_t [ALU_ARB_NUM_REQ-1:0]     req_control,
   output logic [ALU_ARB_NUM_REQ-1:0]             rsp_valid,
   input  logic [ALU_ARB_NUM_REQ-1:0]             rsp_ready,
   output logic [N-1:0]                           rsp_result,
   output logic                                   rsp_overflow,
   output logic                                   rsp_zero,
   output logic                                   rsp_equal,
   output logic                                   busy,
   output logic [15:0]                            ops_done
);

   alu_arb_state_t state_q, state_d;
   logic [N-1:0]   a_q, b_q, res_q;
   alu_control_t   ctrl_q;
   logic           gid_q, last_grant_q;
   logic           ovf_q, zero_q, eq_q;
   logic [15:0]    ops_done_q;
   logic [1:0]     grant;
   logic           accept, rsp_done, sel;
   logic [N-1:0]   alu_res;
   logic           alu_ovf, alu_zero, alu_eq;

   always_comb begin
      grant = 2'b00;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      if (&req_valid)
         grant = last_grant_q ? 2'b01 : 2'b10;
      else
         grant = req_valid;
`else
      grant = req_valid[0] ? 2'b01 : {req_valid[1], 1'b0};
`endif
   end

`ifndef ALU_ARB_ROUND_ROBIN_EN
   // Tracked in both builds so switching arbitration changes nothing else
   logic last_grant_unused;
   assign last_grant_unused = last_grant_q;
`endif

   assign accept   = |(req_valid & req_ready);
   assign sel      = req_ready[1];
   assign rsp_done = (state_q == ARB_RESP) && rsp_ready[gid_q];

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: if (accept) state_d = ARB_EXEC;
         ARB_EXEC: state_d = ARB_RESP;
         ARB_RESP: if (rsp_done) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      req_ready = 2'b00;
      rsp_valid = 2'b00;
      busy      = 1'b1;
      unique case (state_q)
         ARB_IDLE: begin
            req_ready = grant;
            busy      = 1'b0;
         end
         ARB_RESP: rsp_valid[gid_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB_IDLE;
         a_q          <= '0;
         b_q          <= '0;
         ctrl_q       <= '0;
         gid_q        <= 1'b0;
         res_q        <= '0;
         ovf_q        <= 1'b0;
         zero_q       <= 1'b0;
         eq_q         <= 1'b0;
         last_grant_q <= 1'b1;
         ops_done_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            a_q    <= req_a[sel];
            b_q    <= req_b[sel];
            ctrl_q <= req_control[sel];
            gid_q  <= sel;
         end
         if (state_q == ARB_EXEC) begin
            res_q  <= alu_res;
            ovf_q  <= alu_ovf;
            zero_q <= alu_zero;
            eq_q   <= alu_eq;
         end
         if (rsp_done) begin
            ops_done_q   <= ops_done_q + 16'd1;
            last_grant_q <= gid_q;
         end
      end
   end

   alu #(N) u_alu (
      .a        (a_q),
      .b        (b_q),
      .control  (ctrl_q),
      .result   (alu_res),
      .overflow (alu_ovf),
      .zero     (alu_zero),
      .equal    (alu_eq)
   );

   assign rsp_result   = res_q;
   assign rsp_overflow = ovf_q;
   assign rsp_zero     = zero_q;
   assign rsp_equal    = eq_q;
   assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an in-order response scoreboard.
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][31:0]      req_a;
   logic [1:0][31:0]      req_b;
   alu_control_t [1:0]    req_control;
   logic [1:0]            rsp_valid;
   logic [1:0]            rsp_ready;
   logic [31:0]           rsp_result;
   logic                  rsp_overflow;
   logic                  rsp_zero;
   logic                  rsp_equal;
   logic                  busy;
   logic [15:0]           ops_done;

   alu_arbiter #(.N(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_control  (req_control),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .rsp_equal    (rsp_equal),
      .busy         (busy),
      .ops_done     (ops_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      alu_control_t ctrl;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  res;
      logic         ovf;
   } op_t;

   typedef struct {
      int           id;
      logic [31:0]  res;
      logic         ovf;
      logic         zero;
      logic         eq;
      int           cyc;
   } exp_t;

   op_t  q0[$];
   op_t  q1[$];
   exp_t sb[$];
   int   grants[$];
   int   exp_grants[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic op_t mk(input alu_control_t c, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] res,
                              input logic ovf);
      op_t o;
      o.ctrl = c;
      o.a    = a;
      o.b    = b;
      o.res  = res;
      o.ovf  = ovf;
      return o;
   endfunction

   task automatic push_exp(input int id, input op_t o);
      exp_t e;
      e.id   = id;
      e.res  = o.res;
      e.ovf  = o.ovf;
      e.zero = (o.res == 32'd0);
      e.eq   = (o.a == o.b);
      e.cyc  = cyc;
      sb.push_back(e);
      grants.push_back(id);
   endtask

   // Called just after a falling edge; returns idle at a falling edge.
   task automatic run(input int budget);
      int         n = 0;
      exp_t       e;
      op_t        o;
      logic [1:0] onehot;
      forever begin
         req_valid[0] = (q0.size() > 0);
         req_valid[1] = (q1.size() > 0);
         if (q0.size() > 0) begin
            req_a[0] = q0[0].a;
            req_b[0] = q0[0].b;
            req_control[0] = q0[0].ctrl;
         end
         if (q1.size() > 0) begin
            req_a[1] = q1[0].a;
            req_b[1] = q1[0].b;
            req_control[1] = q1[0].ctrl;
         end
         #1;
         if ((rsp_valid & rsp_ready) != 2'b00) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", {62'd0, rsp_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               onehot = 2'b00;
               onehot[e.id] = 1'b1;
               chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, onehot});
               chk("rsp_result", {32'd0, rsp_result}, {32'd0, e.res});
               chk("rsp_overflow", {63'd0, rsp_overflow}, {63'd0, e.ovf});
               chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, e.zero});
               chk("rsp_equal", {63'd0, rsp_equal}, {63'd0, e.eq});
               chk("rsp_latency", 64'(cyc - e.cyc), 64'd2);
            end
         end
         if (req_valid[0] && req_ready[0]) begin
            o = q0.pop_front();
            push_exp(0, o);
         end else if (req_valid[1] && req_ready[1]) begin
            o = q1.pop_front();
            push_exp(1, o);
         end
         cyc++;
         n++;
         @(negedge clk);
         if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) break;
         if (n >= budget) begin
            chk("run_timeout_pending",
                64'(q0.size() + q1.size() + sb.size()), 64'd0);
            q0.delete();
            q1.delete();
            sb.delete();
            break;
         end
      end
      req_valid = 2'b00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = 2'b00;
      req_a       = '0;
      req_b       = '0;
      req_control = '0;
      rsp_ready   = 2'b11;
      do_reset();

      // Reset state
      #1;
      chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_ops_done", {48'd0, ops_done}, 64'd0);
      chk("rst_result", {32'd0, rsp_result}, 64'd0);
      chk("rst_flags", {61'd0, rsp_overflow, rsp_zero, rsp_equal}, 64'd0);
      @(negedge clk);

      // Req0 AND
      q0.push_back(mk(ALU_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0,
                      32'h00F0_00F0, 1'b0));
      run(20);
      chk("and_ops_done", {48'd0, ops_done}, 64'd1);
      chk("and_busy", {63'd0, busy}, 64'd0);

      // Req1 shifts, overflowing add, unused code
      q1.push_back(mk(ALU_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0));
      q1.push_back(mk(ALU_SLL, 32'h0000_0001, 32'd32, 32'h0000_0000, 1'b0));
      q1.push_back(mk(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1));
      q1.push_back(mk(ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b0));
      q1.push_back(mk(alu_control_t'(4'd9), 32'd5, 32'd5, 32'd0, 1'b0));
      run(60);
      chk("req1_ops_done", {48'd0, ops_done}, 64'd6);

      // Contention from reset
      do_reset();
      grants.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(mk(ALU_ADD, 32'(100 + i), 32'd1, 32'(101 + i), 1'b0));
         q1.push_back(mk(ALU_OR, 32'(i << 8), 32'h0000_0001,
                         32'((i << 8) | 1), 1'b0));
      end
`ifdef ALU_ARB_ROUND_ROBIN_EN
      exp_grants = '{0, 1, 0, 1, 0, 1};
`else
      exp_grants = '{0, 0, 0, 1, 1, 1};
`endif
      run(100);
      chk("arb_count", 64'(grants.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < grants.size())
            chk($sformatf("arb_grant%0d", i), 64'(grants[i]),
                64'(exp_grants[i]));
      end
      chk("arb_ops_done", {48'd0, ops_done}, 64'd6);

      // Backpressure on requester 0
      rsp_ready      = 2'b00;
      req_valid      = 2'b01;
      req_a[0]       = 32'h1234_0000;
      req_b[0]       = 32'h0000_5678;
      req_control[0] = ALU_OR;
      #1;
      chk("bp_req_ready", {62'd0, req_ready}, 64'd1);
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("bp_exec_busy", {63'd0, busy}, 64'd1);
      chk("bp_exec_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      @(negedge clk);
      req_valid      = 2'b10;
      req_a[1]       = 32'd7;
      req_b[1]       = 32'd8;
      req_control[1] = ALU_ADD;
      rsp_ready      = 2'b10;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("bp_rsp_valid", {62'd0, rsp_valid}, 64'd1);
         chk("bp_result", {32'd0, rsp_result}, 64'h1234_5678);
         chk("bp_req_ready", {62'd0, req_ready}, 64'd0);
         chk("bp_busy", {63'd0, busy}, 64'd1);
         @(negedge clk);
      end
      chk("bp_ops_held", {48'd0, ops_done}, 64'd6);
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      #1;
      chk("bp_release_valid", {62'd0, rsp_valid}, 64'd1);
      @(negedge clk);
      #1;
      chk("bp_done_ops", {48'd0, ops_done}, 64'd7);
      chk("bp_done_busy", {63'd0, busy}, 64'd0);
      chk("bp_done_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      rsp_ready = 2'b11;
      @(negedge clk);

      // Reset while in EXEC
      req_valid      = 2'b01;
      req_a[0]       = 32'd2;
      req_b[0]       = 32'd3;
      req_control[0] = ALU_ADD;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      chk("rstx_exec_busy", {63'd0, busy}, 64'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("rstx_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rstx_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rstx_result", {32'd0, rsp_result}, 64'd0);
      chk("rstx_flags", {61'd0, rsp_overflow, rsp_zero, rsp_equal}, 64'd0);
      chk("rstx_busy", {63'd0, busy}, 64'd0);
      chk("rstx_ops_done", {48'd0, ops_done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rstx_no_rsp", {62'd0, rsp_valid}, 64'd0);
         @(negedge clk);
      end
      q0.push_back(mk(ALU_ADD, 32'd10, 32'd20, 32'd30, 1'b0));
      run(20);
      chk("rstx_next_ops", {48'd0, ops_done}, 64'd1);

      // Counter wrap
      force dut.ops_done_q = 16'hFFFF;
      @(negedge clk);
      release dut.ops_done_q;
      #1;
      chk("wrap_preload", {48'd0, ops_done}, 64'hFFFF);
      @(negedge clk);
      q1.push_back(mk(ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0));
      run(20);
      chk("wrap_ops_done", {48'd0, ops_done}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
